// File: rtl/emissor_pedidos.sv
// rtl/emissor_pedidos.sv - request-issuing front end for the elevator manager entry interface
//
// Captures call-button presses (origin/destination pairs) into a small FIFO,
// validates them, and presents each queued request to the manager as a
// stable origem/destino pair with a held novaEntrada level.  A request is
// held until the manager acknowledges it (aceito); on timeout the same head
// entry is re-presented.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   botao        in   request button level; rising edge = new request
//   origem_in    in   [3:0] origin floor sampled on the botao rising edge
//   destino_in   in   [3:0] destination floor sampled on the botao rising edge
//   aceito       in   manager acknowledge level, sampled each cycle
//   origem       out  [3:0] origin presented to the manager (registered)
//   destino      out  [3:0] destination presented to the manager (registered)
//   novaEntrada  out  request-present level (registered)
//   fila_vazia   out  FIFO empty
//   fila_cheia   out  FIFO full
//   ocupado      out  presentation FSM not idle
//   descartados  out  [3:0] saturating count of rejected presses
//   erro_timeout out  one-cycle pulse on each timeout

module emissor_pedidos #(
  parameter int NUM_ANDARES = 16,
  parameter int PROF_FILA   = 4,
  parameter int T_ALTO      = 2,
  parameter int T_BAIXO     = 2,
  parameter int T_TIMEOUT   = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao,
  input  logic [3:0] origem_in,
  input  logic [3:0] destino_in,
  input  logic       aceito,
  output logic [3:0] origem,
  output logic [3:0] destino,
  output logic       novaEntrada,
  output logic       fila_vazia,
  output logic       fila_cheia,
  output logic       ocupado,
  output logic [3:0] descartados,
  output logic       erro_timeout
);

  localparam int PW   = (PROF_FILA > 1) ? $clog2(PROF_FILA) : 1;
  localparam int CMAX = (T_TIMEOUT > T_BAIXO) ? T_TIMEOUT : T_BAIXO;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    CARREGA   = 2'd1,
    ATIVO     = 2'd2,
    INTERVALO = 2'd3
  } estado_t;

  estado_t       r_estado;
  estado_t       w_prox;

  logic          r_botao_prev;
  logic [7:0]    r_mem [PROF_FILA];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [CW-1:0] r_cnt;
  logic          r_ack_l;
  logic [3:0]    r_origem;
  logic [3:0]    r_destino;
  logic [3:0]    r_desc;
  logic          r_nova;
  logic          r_erro;

  logic          w_press;
  logic          w_valido;
  logic          w_cheia;
  logic          w_vazia;
  logic          w_push;
  logic          w_drop;
  logic          w_pop;
  logic          w_timeout;
  logic          w_carga;

  // ------------------------------------------------------------------
  // Press detection and validation
  // ------------------------------------------------------------------
  assign w_press  = botao & ~r_botao_prev;
  assign w_valido = (origem_in != destino_in) &&
                    ({1'b0, origem_in}  < 5'(NUM_ANDARES)) &&
                    ({1'b0, destino_in} < 5'(NUM_ANDARES));

  assign w_cheia  = (r_count == (PW+1)'(PROF_FILA));
  assign w_vazia  = (r_count == '0);

  // A full FIFO still takes a push when the head is popped on the same edge.
  assign w_push   = w_press & w_valido & (~w_cheia | w_pop);
  assign w_drop   = w_press & ~w_push;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_botao_prev <= 1'b0;
    end else begin
      r_botao_prev <= botao;
    end
  end

  // ------------------------------------------------------------------
  // FIFO storage (data only, pointers carry the reset state)
  // ------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {origem_in, destino_in};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Presentation FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado <= OCIOSO;
    end else begin
      r_estado <= w_prox;
    end
  end

  always_comb begin
    w_prox    = r_estado;
    w_pop     = 1'b0;
    w_timeout = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (!w_vazia) begin
          w_prox = CARREGA;
        end
      end
      CARREGA: begin
        w_prox = ATIVO;
      end
      ATIVO: begin
        // Acknowledge wins over timeout when both fall on the same cycle.
        if ((r_cnt >= CW'(T_ALTO)) && (r_ack_l || aceito)) begin
          w_pop  = 1'b1;
          w_prox = INTERVALO;
        end else if (r_cnt == CW'(T_TIMEOUT)) begin
          w_timeout = 1'b1;
          w_prox    = INTERVALO;
        end
      end
      INTERVALO: begin
        if (r_cnt >= CW'(T_BAIXO)) begin
          w_prox = OCIOSO;
        end
      end
      default: begin
        w_prox = OCIOSO;
      end
    endcase
  end

  // The pair is loaded on the edge that enters CARREGA, so it is already
  // stable for the whole CARREGA cycle before novaEntrada rises.
  assign w_carga = (r_estado == OCIOSO) && (w_prox == CARREGA);

  // Cycle counter shared by ATIVO and INTERVALO; it reads 1 in the first
  // cycle of each state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (w_prox != r_estado) begin
      r_cnt <= CW'(1);
    end else if ((r_estado == ATIVO) || (r_estado == INTERVALO)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Acknowledge latch: cleared while loading, so aceito before ATIVO is ignored.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ack_l <= 1'b0;
    end else if (r_estado == CARREGA) begin
      r_ack_l <= 1'b0;
    end else if ((r_estado == ATIVO) && aceito) begin
      r_ack_l <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Registered outputs
  // ------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_origem  <= 4'd0;
      r_destino <= 4'd0;
      r_nova    <= 1'b0;
      r_erro    <= 1'b0;
      r_desc    <= 4'd0;
    end else begin
      if (w_carga) begin
        {r_origem, r_destino} <= r_mem[r_rd_ptr];
      end
      r_nova <= (w_prox == ATIVO);
      r_erro <= w_timeout;
      if (w_drop && (r_desc != 4'hF)) begin
        r_desc <= r_desc + 4'd1;
      end
    end
  end

  assign origem       = r_origem;
  assign destino      = r_destino;
  assign novaEntrada  = r_nova;
  assign erro_timeout = r_erro;
  assign descartados  = r_desc;
  assign fila_vazia   = w_vazia;
  assign fila_cheia   = w_cheia;
  assign ocupado      = (r_estado != OCIOSO);

endmodule

// File: tb/tb_emissor_pedidos.sv
// tb/tb_emissor_pedidos.sv - self-checking bench for emissor_pedidos

module tb_emissor_pedidos;

  localparam int NA = 12;
  localparam int PF = 4;
  localparam int TA = 2;
  localparam int TB = 2;
  localparam int TT = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       botao;
  logic [3:0] origem_in;
  logic [3:0] destino_in;
  logic       aceito;
  logic [3:0] origem;
  logic [3:0] destino;
  logic       novaEntrada;
  logic       fila_vazia;
  logic       fila_cheia;
  logic       ocupado;
  logic [3:0] descartados;
  logic       erro_timeout;

  emissor_pedidos #(
    .NUM_ANDARES(NA), .PROF_FILA(PF), .T_ALTO(TA), .T_BAIXO(TB), .T_TIMEOUT(TT)
  ) dut (
    .clock(clock), .reset(reset), .botao(botao), .origem_in(origem_in),
    .destino_in(destino_in), .aceito(aceito), .origem(origem), .destino(destino),
    .novaEntrada(novaEntrada), .fila_vazia(fila_vazia), .fila_cheia(fila_cheia),
    .ocupado(ocupado), .descartados(descartados), .erro_timeout(erro_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: queue of accepted requests plus presentation tracking.
  logic [7:0] q[$];
  int         exp_desc;
  logic       m_prev_botao;
  logic       prev_nova;
  logic [3:0] prev_o, prev_d;
  int         act_cyc;
  int         ack_at;
  int         force_ack = -1;
  int         low_cnt;
  bit         have_fall;
  bit         gap_exact;
  bit         noise_en = 0;

  task automatic modelo_reset();
    q.delete();
    exp_desc     = 0;
    m_prev_botao = 1'b0;
    prev_nova    = 1'b0;
    have_fall    = 0;
    low_cnt      = 0;
    act_cyc      = 0;
  endtask

  task automatic monitor();
    bit         press, valid, rise, fall, acked;
    int         dur;
    logic [7:0] cab;
    if (!reset) begin
      modelo_reset();
      confere("rst_nova", novaEntrada, 0);
      confere("rst_vazia", fila_vazia, 1);
      prev_o = origem;
      prev_d = destino;
      return;
    end
    rise  = novaEntrada && !prev_nova;
    fall  = !novaEntrada && prev_nova;
    acked = 0;
    if (fall) begin
      acked = (ack_at >= 1) && (ack_at <= TT);
      dur   = acked ? ((ack_at < TA) ? TA : ack_at) : TT;
      confere("duracao_alto", act_cyc, dur);
      if (acked && q.size() > 0) void'(q.pop_front());
      low_cnt   = 1;
      have_fall = 1;
    end else if (!novaEntrada) begin
      low_cnt++;
    end
    confere("erro_timeout", erro_timeout, fall && !acked);

    press        = botao && !m_prev_botao;
    m_prev_botao = botao;
    if (press) begin
      valid = (origem_in != destino_in) && (origem_in < NA) && (destino_in < NA);
      if (valid && q.size() < PF) q.push_back({origem_in, destino_in});
      else if (exp_desc < 15) exp_desc++;
    end
    confere("fila_vazia", fila_vazia, q.size() == 0);
    confere("fila_cheia", fila_cheia, q.size() == PF);
    confere("descartados", descartados, exp_desc);

    if (have_fall && !novaEntrada) begin
      if (low_cnt <= TB) confere("ocupado_intervalo", ocupado, 1);
      if (low_cnt == TB + 1) begin
        confere("ocupado_ocioso", ocupado, 0);
        gap_exact = (q.size() > 0);
      end
    end

    if (rise) begin
      confere("fila_modelo_tem_pedido", q.size() > 0, 1);
      if (q.size() > 0) begin
        cab = q[0];
        confere("origem_apresentada", origem, cab[7:4]);
        confere("destino_apresentado", destino, cab[3:0]);
      end
      confere("origem_estavel_antes", origem, prev_o);
      confere("destino_estavel_antes", destino, prev_d);
      if (have_fall) begin
        if (gap_exact) confere("intervalo_exato", low_cnt, TB + 2);
        else           confere("intervalo_minimo", low_cnt >= TB + 2, 1);
      end
      act_cyc = 1;
      if (force_ack >= 0) ack_at = force_ack;
      else if ($urandom_range(0, 3) == 0) ack_at = $urandom_range(TT - 1, TT + 2);
      else ack_at = $urandom_range(1, 5);
    end else if (novaEntrada) begin
      act_cyc++;
      confere("alto_limite", act_cyc <= TT, 1);
      confere("origem_fixa_alto", origem, prev_o);
      confere("destino_fixo_alto", destino, prev_d);
    end
    prev_nova = novaEntrada;
    prev_o    = origem;
    prev_d    = destino;
  endtask

  task automatic ciclo();
    @(posedge clock);
    #1;
    monitor();
    if (novaEntrada) aceito = (act_cyc == ack_at);
    else             aceito = noise_en && ($urandom_range(0, 3) == 0);
  endtask

  task automatic aperta(input logic [3:0] o, input logic [3:0] d);
    botao = 1'b1; origem_in = o; destino_in = d;
    ciclo();
    botao = 1'b0;
    ciclo();
  endtask

  task automatic espera_ocioso(input int limite);
    for (int i = 0; i < limite; i++) begin
      if (!ocupado && q.size() == 0) break;
      ciclo();
    end
    confere("espera_ocioso", ocupado, 0);
  endtask

  initial begin
    reset = 1'b0; botao = 1'b0; aceito = 1'b0; origem_in = 4'd0; destino_in = 4'd0;
    modelo_reset();
    prev_o = 4'd0; prev_d = 4'd0; gap_exact = 0; ack_at = 0;
    #12;
    confere("reset_origem", origem, 0);
    confere("reset_destino", destino, 0);
    confere("reset_nova", novaEntrada, 0);
    confere("reset_erro", erro_timeout, 0);
    confere("reset_desc", descartados, 0);
    confere("reset_vazia", fila_vazia, 1);
    confere("reset_cheia", fila_cheia, 0);
    confere("reset_ocupado", ocupado, 0);
    reset = 1'b1;
    ciclo(); ciclo();

    // Single request (3,9), ack in 3rd ATIVO cycle; latency k+1 / k+2.
    force_ack = 3;
    botao = 1'b1; origem_in = 4'd3; destino_in = 4'd9;
    ciclo();
    botao = 1'b0;
    ciclo();
    confere("lat_origem_k1", origem, 3);
    confere("lat_destino_k1", destino, 9);
    confere("lat_nova_k1", novaEntrada, 0);
    ciclo();
    confere("lat_nova_k2", novaEntrada, 1);
    espera_ocioso(100);

    // Early ack latched in ATIVO cycle 1.
    force_ack = 1;
    aperta(4'd1, 4'd2);
    espera_ocioso(100);

    // Queue fill and drop, with timeouts (no aceito).
    force_ack = 0;
    aperta(4'd1, 4'd2);
    aperta(4'd2, 4'd3);
    aperta(4'd4, 4'd5);
    aperta(4'd6, 4'd7);
    confere("cheia_apos_4", fila_cheia, 1);
    aperta(4'd8, 4'd9);
    confere("desc_apos_5", descartados, 1);
    aperta(4'd5, 4'd5);
    aperta(4'd3, 4'd15);
    confere("desc_invalidos", descartados, 3);
    for (int i = 0; i < 17; i++) aperta(4'(i % 16), 4'(i % 16));
    confere("desc_saturado", descartados, 15);

    // Reset mid-ATIVO with a loaded queue.
    for (int i = 0; i < 100; i++) begin
      if (novaEntrada) break;
      ciclo();
    end
    confere("ativo_antes_reset", novaEntrada, 1);
    #2;
    reset = 1'b0; aceito = 1'b0;
    #1;
    confere("rst_assinc_nova", novaEntrada, 0);
    confere("rst_assinc_vazia", fila_vazia, 1);
    confere("rst_assinc_desc", descartados, 0);
    confere("rst_assinc_ocupado", ocupado, 0);
    ciclo(); ciclo();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ciclo();
      confere("sem_apresentacao_pos_reset", novaEntrada, 0);
    end

    // Randomized traffic against the model.
    force_ack = -1;
    noise_en  = 1;
    for (int i = 0; i < 2500; i++) begin
      if (botao) begin
        if ($urandom_range(0, 1) == 0) botao = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        botao = 1'b1;
        if ($urandom_range(0, 4) != 0) begin
          origem_in  = 4'($urandom_range(0, NA - 1));
          destino_in = 4'(($urandom_range(1, NA - 1) + origem_in) % NA);
        end else begin
          origem_in  = 4'($urandom_range(0, 15));
          destino_in = 4'($urandom_range(0, 15));
        end
      end
      ciclo();
    end
    botao = 1'b0;
    espera_ocioso(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/emissor_pedidos.md
Name: emissor_pedidos

Overview:
- Request-issuing front end for the elevator manager datapath. It sits on the opposite side of the manager's `origem`/`destino`/`novaEntrada` entry interface.
- Captures call-button presses (origin/destination pairs) into a small FIFO and validates them.
- Presents each request to the manager as a stable origin/destination pair with a held `novaEntrada` level, so the manager's edge detector sees exactly one rising edge per request.
- Holds each request until the manager acknowledges it; retries on timeout.

Parameters:
- NUM_ANDARES, 16, number of floors; valid floor codes are 0..NUM_ANDARES-1 (max 16).
- PROF_FILA, 4, FIFO depth in entries (power of 2, ≥2).
- T_ALTO, 2, minimum cycles `novaEntrada` stays high per presentation (≥1).
- T_BAIXO, 2, minimum cycles `novaEntrada` stays low between presentations (≥1).
- T_TIMEOUT, 255, max cycles high without `aceito` before retry (> T_ALTO).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- botao  in  1  request button level; rising edge = new request.
- origem_in  in  4  origin floor sampled on the `botao` rising edge.
- destino_in  in  4  destination floor sampled on the `botao` rising edge.
- aceito  in  1  manager acknowledge; level, sampled each cycle.
- origem  out  4  origin presented to the manager (registered).
- destino  out  4  destination presented to the manager (registered).
- novaEntrada  out  1  request-present level (registered).
- fila_vazia  out  1  FIFO empty.
- fila_cheia  out  1  FIFO full.
- ocupado  out  1  FSM not in OCIOSO.
- descartados  out  4  saturating count of rejected presses.
- erro_timeout  out  1  one-cycle pulse on each timeout.

Behaviour:
- Reset (reset=0, async)
  - FIFO emptied; pointers and count 0.
  - FSM → OCIOSO; all counters 0.
  - `origem`=`destino`=0, `novaEntrada`=0, `erro_timeout`=0, `descartados`=0, `fila_vazia`=1, `fila_cheia`=0.
  - Internal `botao_prev`=0. A reset asserted mid-presentation drops `novaEntrada` immediately, and the in-flight entry is lost.
- Edge detection
  - `press` = `botao` & ~`botao_prev`; `botao_prev` is registered every cycle.
  - A held button produces exactly one press.
- Validation on press
  - Valid iff `origem_in` ≠ `destino_in`, and both < NUM_ANDARES.
  - Valid and (not full, or pop in the same cycle) → write {`origem_in`,`destino_in`} at the tail on that edge.
  - Otherwise `descartados` += 1, saturating at 15.
  - Simultaneous push and pop on a full FIFO is accepted, and the count is unchanged.
- FSM states and transitions
  - OCIOSO: `novaEntrada`=0. If FIFO non-empty → CARREGA.
  - CARREGA (1 cycle): register `origem`/`destino` from the FIFO head. → ATIVO.
    - Outputs are therefore stable ≥1 cycle before `novaEntrada` rises.
  - ATIVO: `novaEntrada`=1; cycle counter `t` starts at 1 on entry.
    - `aceito` seen in any ATIVO cycle is latched into `ack_l`.
    - Exit when `t` ≥ T_ALTO and (`ack_l` or `aceito`): pop the head on that edge → INTERVALO.
    - Else if `t` = T_TIMEOUT: no pop; `erro_timeout`=1 for one cycle → INTERVALO, then retry the same head.
  - INTERVALO: `novaEntrada`=0; `origem`/`destino` held; lasts T_BAIXO cycles → OCIOSO.
- Latency
  - Press sampled at edge k into an empty, idle FIFO → CARREGA at k+1 → `novaEntrada`=1 from edge k+2.
  - Back-to-back queued entries: rising edges are separated by ≥ T_ALTO + T_BAIXO + 2 cycles.
- FIFO addressing
  - Pointers wrap modulo PROF_FILA.
  - Count is 0..PROF_FILA.
  - `fila_cheia` = (count == PROF_FILA); `fila_vazia` = (count == 0).
- Other rules
  - `aceito` outside ATIVO is ignored.
  - `origem`/`destino` never change while `novaEntrada`=1.

Test Plan:
- Single request: reset, press (3,9) once, `aceito` high 1 cycle at the 3rd ATIVO cycle.
  → `origem`=3, `destino`=9 one cycle before `novaEntrada` rises (2 cycles after the press edge); `novaEntrada` high 3 cycles; pop; `fila_vazia`=1; `novaEntrada` low for exactly 2 cycles before OCIOSO.
- Early ack: `aceito` pulsed in ATIVO cycle 1 with T_ALTO=2.
  → `ack_l` latched; `novaEntrada` high exactly 2 cycles; one pop.
- Queue fill and drop: five valid presses (1,2),(2,3),(4,5),(6,7),(8,9) with no `aceito`.
  → `fila_cheia`=1 after the 4th; 5th counted (`descartados`=1); head (1,2) presented first.
- Invalid presses: (5,5) and (3,15) with NUM_ANDARES=12.
  → both rejected, `descartados`=2, FIFO unchanged; 17 invalid presses → `descartados` saturates at 15.
- Timeout: T_TIMEOUT=10, no `aceito`.
  → `novaEntrada` high 10 cycles, `erro_timeout` 1-cycle pulse, low for T_BAIXO cycles, same (origem,destino) re-presented; count unchanged.
- Reset mid-ATIVO with 3 entries queued.
  → `novaEntrada`=0 asynchronously, `fila_vazia`=1, `descartados`=0; no presentation after reset release until a new press.
